// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the two-port data_memory arbiter.
// Holds the FSM state encoding, requester-id width and the address legality check.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int MEM_AW_DEF = 10;
  localparam int REQ_ID_W   = 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  // Word accesses only, and nothing above the decoded memory window.
  function automatic logic addr_err(input logic [ADDR_W_DEF-1:0] addr, input int mem_aw);
    logic [ADDR_W_DEF-1:0] hi;
    hi = addr >> mem_aw;
    return (addr[1:0] != 2'b00) || (hi != '0);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// One requester port of the arbiter: valid/ready request channel plus a one-cycle response.
// The requester uses the master modport, the arbiter the slave modport.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              valid;
  logic              ready;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] wdata;
  logic              rsp_valid;
  logic [ADDR_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output valid, write, addr, wdata,
    input  ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  valid, write, addr, wdata,
    output ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_arb_pick.sv
// Two-way grant selection producing a one-hot grant from the request valids.
// MEM_ARB_RR_EN selects round-robin on contention; otherwise requester 0 has fixed priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0]          valid,
  input  logic [REQ_ID_W-1:0] last_grant,
  output logic [1:0]          grant
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    grant = valid;
    // On contention hand the grant to whoever did not win last time.
    if (valid == 2'b11) begin
      grant = (last_grant == REQ_ID_W'(1)) ? 2'b01 : 2'b10;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;

  always_comb begin
    grant = 2'b00;
    if (valid[0]) begin
      grant = 2'b01;
    end else if (valid[1]) begin
      grant = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer serialising two requesters onto data_memory: IDLE -> ACCESS -> RESP.
// Arbitration policy follows MEM_ARB_RR_EN (round-robin when defined, fixed priority otherwise).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int MEM_AW = MEM_AW_DEF
) (
  input  logic              clock,
  input  logic              reset,
  mem_arbiter_if.slave      req0,
  mem_arbiter_if.slave      req1,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] endereco,
  output logic [ADDR_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_data
);

  state_t              state_q, state_d;
  logic                op_write_q, op_write_d;
  logic [ADDR_W-1:0]   op_addr_q, op_addr_d;
  logic [ADDR_W-1:0]   op_wdata_q, op_wdata_d;
  logic [REQ_ID_W-1:0] op_id_q, op_id_d;
  logic                op_err_q, op_err_d;
  logic [ADDR_W-1:0]   rdata_q, rdata_d;
  logic [REQ_ID_W-1:0] last_grant_q, last_grant_d;
  logic [1:0]          rsp_valid_q, rsp_valid_d;

  logic [1:0]          valid;
  logic [1:0]          grant;
  logic [1:0]          ready;
  logic                hs;
  logic                sel_write;
  logic [ADDR_W-1:0]   sel_addr;
  logic [ADDR_W-1:0]   sel_wdata;
  logic                in_access;

  assign valid = {req1.valid, req0.valid};

  mem_arb_pick u_pick (
    .valid      (valid),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  always_comb begin
    ready        = (state_q == S_IDLE && !reset) ? grant : 2'b00;
    hs           = |ready;
    sel_write    = grant[1] ? req1.write : req0.write;
    sel_addr     = grant[1] ? req1.addr  : req0.addr;
    sel_wdata    = grant[1] ? req1.wdata : req0.wdata;

    state_d      = state_q;
    op_write_d   = op_write_q;
    op_addr_d    = op_addr_q;
    op_wdata_d   = op_wdata_q;
    op_id_d      = op_id_q;
    op_err_d     = op_err_q;
    rdata_d      = rdata_q;
    last_grant_d = last_grant_q;
    rsp_valid_d  = 2'b00;

    case (state_q)
      S_IDLE: begin
        if (hs) begin
          state_d      = S_ACCESS;
          op_write_d   = sel_write;
          op_addr_d    = sel_addr;
          op_wdata_d   = sel_wdata;
          op_id_d      = REQ_ID_W'(grant[1]);
          op_err_d     = addr_err(sel_addr, MEM_AW);
          last_grant_d = REQ_ID_W'(grant[1]);
        end
      end
      S_ACCESS: begin
        state_d              = S_RESP;
        rdata_d              = (!op_err_q && !op_write_q) ? read_data : '0;
        rsp_valid_d[op_id_q] = 1'b1;
      end
      S_RESP: begin
        state_d = S_IDLE;
        rdata_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      op_write_q   <= 1'b0;
      op_addr_q    <= '0;
      op_wdata_q   <= '0;
      op_id_q      <= '0;
      op_err_q     <= 1'b0;
      rdata_q      <= '0;
      last_grant_q <= REQ_ID_W'(1);
      rsp_valid_q  <= 2'b00;
    end else begin
      state_q      <= state_d;
      op_write_q   <= op_write_d;
      op_addr_q    <= op_addr_d;
      op_wdata_q   <= op_wdata_d;
      op_id_q      <= op_id_d;
      op_err_q     <= op_err_d;
      rdata_q      <= rdata_d;
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

  // Memory strobes are gated by reset so an interrupted ACCESS never commits a store.
  assign in_access  = (state_q == S_ACCESS);
  assign MemRead    = in_access && !op_err_q && !op_write_q && !reset;
  assign MemWrite   = in_access && !op_err_q &&  op_write_q && !reset;
  assign endereco   = (in_access && !op_err_q) ? op_addr_q  : '0;
  assign write_data = (in_access && !op_err_q) ? op_wdata_q : '0;

  assign req0.ready     = ready[0];
  assign req1.ready     = ready[1];
  assign req0.rsp_valid = rsp_valid_q[0];
  assign req1.rsp_valid = rsp_valid_q[1];
  assign req0.rsp_err   = rsp_valid_q[0] && op_err_q;
  assign req1.rsp_err   = rsp_valid_q[1] && op_err_q;
  assign req0.rsp_rdata = rsp_valid_q[0] ? rdata_q : '0;
  assign req1.rsp_rdata = rsp_valid_q[1] ? rdata_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural data_memory and a response scoreboard.
// Expected grant order depends on MEM_ARB_RR_EN, matching the build of the design.
module tb_mem_arbiter;

  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] endereco;
  logic [31:0] write_data;
  logic [31:0] read_data;

  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:255];
  logic        mem_init;
  exp_t        sb[$];
  int          cyc;
  int          n_assert;
  int          n_fail;
  int          exp_g[4];

  mem_arbiter_if #(.ADDR_W(32)) u_if0 ();
  mem_arbiter_if #(.ADDR_W(32)) u_if1 ();

  mem_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .req0       (u_if0),
    .req1       (u_if1),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .endereco   (endereco),
    .write_data (write_data),
    .read_data  (read_data)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // data_memory model: combinational read, write on the clock edge
  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
    end else if (MemWrite) begin
      mem[endereco[9:2]] <= write_data;
    end
  end
  assign read_data = mem[endereco[9:2]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int p, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input int hc);
    exp_t e;
    logic er;
    er      = (a[1:0] != 2'b00) || (a[31:10] != '0);
    e.id    = p;
    e.err   = er;
    e.rdata = (!er && !w) ? ref_mem[a[9:2]] : 32'h0;
    e.cyc   = hc + 2;
    if (!er && w) ref_mem[a[9:2]] = d;
    sb.push_back(e);
    $display("req%0d %s addr=0x%08h wdata=0x%08h handshake at cycle %0d", p,
             w ? "store" : "load ", a, d, hc);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // One request on port p; checks the memory strobes in the ACCESS cycle.
  task automatic issue(input int p, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input bit rst_access);
    bit   got;
    int   hc;
    logic er;
    got = 1'b0;
    hc  = 0;
    er  = (a[1:0] != 2'b00) || (a[31:10] != '0);
    @(posedge clock); #1;
    if (p == 0) begin
      u_if0.valid = 1'b1; u_if0.write = w; u_if0.addr = a; u_if0.wdata = d;
    end else begin
      u_if1.valid = 1'b1; u_if1.write = w; u_if1.addr = a; u_if1.wdata = d;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      if ((p == 0) ? u_if0.ready : u_if1.ready) begin
        got = 1'b1;
        hc  = cyc;
      end else begin
        @(posedge clock); #1;
      end
    end
    check("handshake_seen", 32'(got), 32'd1);
    if (got) begin
      check("other_ready_low", 32'((p == 0) ? u_if1.ready : u_if0.ready), 32'd0);
      if (!rst_access) push_exp(p, w, a, d, hc);
      @(posedge clock); #1;
      u_if0.valid = 1'b0;
      u_if1.valid = 1'b0;
      if (rst_access) reset = 1'b1;
      @(negedge clock);
      check("access_memread",  32'(MemRead),  32'(!er && !w && !rst_access));
      check("access_memwrite", 32'(MemWrite), 32'(!er &&  w && !rst_access));
      if (!rst_access) begin
        check("access_endereco",   endereco,   er ? 32'h0 : a);
        check("access_write_data", write_data, er ? 32'h0 : d);
      end else begin
        @(posedge clock); #1;
        @(negedge clock);
        check("rst_ready0",     32'(u_if0.ready),     32'd0);
        check("rst_rsp0_valid", 32'(u_if0.rsp_valid), 32'd0);
        check("rst_memwrite",   32'(MemWrite),        32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
      end
    end else begin
      u_if0.valid = 1'b0;
      u_if1.valid = 1'b0;
    end
  endtask

  // Response scoreboard: every rsp pulse must match the oldest outstanding request.
  always @(negedge clock) begin
    if (!reset && (u_if0.rsp_valid || u_if1.rsp_valid)) begin
      exp_t e;
      int   id;
      id = u_if1.rsp_valid ? 1 : 0;
      check("rsp_single_port", 32'(u_if0.rsp_valid && u_if1.rsp_valid), 32'd0);
      check("rsp_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("rsp_id",      32'(id), 32'(e.id));
        check("rsp_rdata",   (id == 0) ? u_if0.rsp_rdata : u_if1.rsp_rdata, e.rdata);
        check("rsp_err",     32'((id == 0) ? u_if0.rsp_err : u_if1.rsp_err), 32'(e.err));
        check("rsp_latency", 32'(cyc), 32'(e.cyc));
        $display("rsp%0d rdata=0x%08h err=%0b at cycle %0d", id,
                 (id == 0) ? u_if0.rsp_rdata : u_if1.rsp_rdata,
                 (id == 0) ? u_if0.rsp_err : u_if1.rsp_err, cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int hcs[3];
    logic r0, r1;
    n_assert = 0;
    n_fail   = 0;
`ifdef MEM_ARB_RR_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'hA500_0000 | 32'(i);
    mem_init = 1'b1;
    reset    = 1'b1;
    u_if0.valid = 1'b1; u_if0.write = 1'b0; u_if0.addr = 32'h10; u_if0.wdata = 32'h0;
    u_if1.valid = 1'b0; u_if1.write = 1'b0; u_if1.addr = 32'h0;  u_if1.wdata = 32'h0;

    // reset state, with a request pending that must not be accepted
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_ready0",     32'(u_if0.ready),     32'd0);
    check("reset_ready1",     32'(u_if1.ready),     32'd0);
    check("reset_rsp0_valid", 32'(u_if0.rsp_valid), 32'd0);
    check("reset_rsp1_valid", 32'(u_if1.rsp_valid), 32'd0);
    check("reset_rsp0_err",   32'(u_if0.rsp_err),   32'd0);
    check("reset_rsp0_rdata", u_if0.rsp_rdata,      32'd0);
    check("reset_memread",    32'(MemRead),         32'd0);
    check("reset_memwrite",   32'(MemWrite),        32'd0);
    check("reset_endereco",   endereco,             32'd0);
    check("reset_write_data", write_data,           32'd0);
    @(posedge clock); #1;
    u_if0.valid = 1'b0;
    mem_init    = 1'b0;
    reset       = 1'b0;

    // store then cross-port load of the same word
    issue(0, 1'b1, 32'h10, 32'hDEAD, 1'b0);
    issue(1, 1'b0, 32'h10, 32'h0, 1'b0);

    // contention: both requesters valid for four grants
    @(posedge clock); #1;
    u_if0.valid = 1'b1; u_if0.write = 1'b0; u_if0.addr = 32'h40; u_if0.wdata = 32'h0;
    u_if1.valid = 1'b1; u_if1.write = 1'b0; u_if1.addr = 32'h44; u_if1.wdata = 32'h0;
    k = 0;
    for (int i = 0; i < 40 && k < 4; i++) begin
      @(negedge clock);
      r0 = u_if0.ready;
      r1 = u_if1.ready;
      if (r0 || r1) begin
        check("grant_onehot", 32'(r0 && r1), 32'd0);
        check($sformatf("grant_%0d", k), 32'(r1 ? 1 : 0), 32'(exp_g[k]));
        push_exp(r1 ? 1 : 0, 1'b0, r1 ? 32'h44 : 32'h40, 32'h0, cyc);
        k++;
      end
      @(posedge clock); #1;
    end
    check("grant_count", 32'(k), 32'd4);
    u_if0.valid = 1'b0;
    u_if1.valid = 1'b0;

    // misaligned and out-of-range loads
    issue(0, 1'b0, 32'h13,  32'h0, 1'b0);
    issue(0, 1'b0, 32'h400, 32'h0, 1'b0);

    // reset lands in the ACCESS cycle of a store: no write, no response
    idle(3);
    issue(0, 1'b1, 32'h20, 32'h55, 1'b1);
    issue(0, 1'b0, 32'h20, 32'h0, 1'b0);

    // valid held through RESP: handshakes three cycles apart
    idle(3);
    u_if0.valid = 1'b1; u_if0.write = 1'b0; u_if0.addr = 32'h10; u_if0.wdata = 32'h0;
    k = 0;
    for (int i = 0; i < 30 && k < 3; i++) begin
      @(negedge clock);
      if (u_if0.ready) begin
        hcs[k] = cyc;
        push_exp(0, 1'b0, 32'h10, 32'h0, cyc);
        k++;
      end
      @(posedge clock); #1;
    end
    u_if0.valid = 1'b0;
    check("b2b_count", 32'(k), 32'd3);
    if (k == 3) begin
      check("b2b_spacing_1", 32'(hcs[1] - hcs[0]), 32'd3);
      check("b2b_spacing_2", 32'(hcs[2] - hcs[1]), 32'd3);
    end

    idle(5);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
